// File: rtl/prod_pkg.sv
// Shared types and constants for the prod free-running word producer.
package prod_pkg;

  localparam int LFSR_W = 16;
  // Taps at bits 15, 13, 12, 10: x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
  localparam int DATA_W = 8;

  typedef enum logic {
    WAIT = 1'b0,
    SEND = 1'b1
  } state_t;

  // One Fibonacci shift-left step; the XOR of the tapped bits enters bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/prod_lfsr.sv
// 16-bit Fibonacci LFSR that advances one step whenever step is high.
module prod_lfsr
  import prod_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_reg;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q_reg <= seed;
    end else if (step) begin
      q_reg <= lfsr_next(q_reg);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/prod.sv
// Free-running producer: emits an incrementing byte with a one-cycle val strobe,
// separated by pseudo-random idle gaps of 1..2^GAP_BITS cycles.
module prod
  import prod_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED,
  parameter int                GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst_b,
  output logic              val,
  output logic [DATA_W-1:0] data
);

  // One extra bit so the counter can hold 2^GAP_BITS.
  localparam int CNT_W = GAP_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_RST = {1'b0, SEED[GAP_BITS-1:0]} + CNT_ONE;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] seq_reg, seq_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              val_reg, val_next;
  logic              lfsr_step;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_nxt;

  prod_lfsr u_lfsr (
    .clk  (clk),
    .rst_b(rst_b),
    .step (lfsr_step),
    .seed (SEED),
    .q    (lfsr_q)
  );

  // The gap is loaded from the value the LFSR is about to take on this edge.
  assign lfsr_nxt = lfsr_next(lfsr_q);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    seq_next   = seq_reg;
    data_next  = data_reg;
    val_next   = 1'b0;
    lfsr_step  = 1'b0;
    case (state_reg)
      WAIT: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = SEND;
          val_next   = 1'b1;
          data_next  = seq_reg;
          seq_next   = seq_reg + 8'd1;
        end
      end
      SEND: begin
        state_next = WAIT;
        lfsr_step  = 1'b1;
        cnt_next   = {1'b0, lfsr_nxt[GAP_BITS-1:0]} + CNT_ONE;
      end
      default: begin
        state_next = WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg <= WAIT;
      cnt_reg   <= CNT_RST;
      seq_reg   <= '0;
      data_reg  <= '0;
      val_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      seq_reg   <= seq_next;
      data_reg  <= data_next;
      val_reg   <= val_next;
    end
  end

  assign val  = val_reg;
  assign data = data_reg;

endmodule

// File: tb/tb_prod.sv
// Scoreboard bench for prod: expected (data, edge-distance) pairs come from a
// reference of the transfer sequence; a monitor pops one entry per val pulse.
module tb_prod;

  localparam logic [15:0] SEED     = 16'hACE1;
  localparam int          GAP_BITS = 2;

  typedef struct {
    logic [7:0] data;
    int         edges;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       val;
  logic [7:0] data;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_xfer   = 0;

  prod #(
    .SEED    (SEED),
    .GAP_BITS(GAP_BITS)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .val  (val),
    .data (data)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference LFSR step: shift left, feedback = b15^b13^b12^b10 into bit 0.
  function automatic int unsigned ref_step(input int unsigned v);
    int unsigned fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 32'hFFFF;
  endfunction

  // Transfer k carries byte k mod 256. The first one follows reset after
  // `gap` rising edges; later ones follow the previous pulse by the SEND
  // cycle plus `gap` idle cycles, the gap coming from the advanced LFSR.
  task automatic build_model(input int n);
    int unsigned v;
    int          gap;
    exp_t        e;
    sb.delete();
    v = SEED;
    for (int k = 0; k < n; k++) begin
      if (k > 0) v = ref_step(v);
      gap    = int'(v % (1 << GAP_BITS)) + 1;
      e.data = 8'(k);
      e.edges = (k == 0) ? gap : gap + 1;
      sb.push_back(e);
    end
  endtask

  // Monitor: samples 1 ns after each rising edge.
  initial begin : monitor
    int         edges;
    bit         prev_val;
    logic [7:0] prev_data;
    exp_t       e;
    edges     = 0;
    prev_val  = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_b) begin
        edges     = 0;
        prev_val  = 1'b0;
        prev_data = 8'h00;
      end else begin
        edges++;
        if (val) begin
          check("pulse_width_prev_val", int'(prev_val), 0);
          if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
          end else begin
            e = sb.pop_front();
            $display("xfer %0d: data=%02h edges=%0d (exp data=%02h edges=%0d)",
                     n_xfer, data, edges, e.data, e.edges);
            check("data", int'(data), int'(e.data));
            check("gap_edges", edges, e.edges);
          end
          n_xfer++;
          edges = 0;
        end else begin
          check("data_hold", int'(data), int'(prev_data));
        end
        prev_val  = val;
        prev_data = data;
      end
    end
  end

  task automatic wait_xfers(input int k, input string name);
    int  target;
    bit  done;
    target = n_xfer + k;
    done   = 1'b0;
    for (int c = 0; c < k * 6 + 20; c++) begin
      @(posedge clk);
      if (n_xfer >= target) begin
        done = 1'b1;
        break;
      end
    end
    check(name, int'(done), 1);
  endtask

  initial begin : stimulus
    int  hold;
    int  offs;
    bit  got;
    rst_b = 1'b1;
    build_model(400);
    #1 rst_b = 1'b0;
    #10;
    check("reset_val", int'(val), 0);
    check("reset_data", int'(data), 0);
    #14 rst_b = 1'b1;

    // Covers first gap, the 4-cycle second gap, and the FF->00 wrap.
    wait_xfers(300, "timeout_initial_run");

    for (int ep = 0; ep < 3; ep++) begin
      wait_xfers(int'($urandom_range(5, 40)), "timeout_pre_reset");
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #2;
        if (val) begin
          got = 1'b1;
          break;
        end
      end
      check("timeout_find_send", int'(got), 1);
      rst_b = 1'b0;
      build_model(400);
      #1;
      check("midsend_val_drop", int'(val), 0);
      check("midsend_data_clear", int'(data), 0);
      hold = int'($urandom_range(1, 3));
      offs = int'($urandom_range(10, 40));
      repeat (hold) @(posedge clk);
      #(offs);
      $display("reset episode %0d: hold=%0d offs=%0d", ep, hold, offs);
      rst_b = 1'b1;
      wait_xfers(20, "timeout_post_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prod.md
PROD -- requirements
Module: prod

Interface
REQ-001 The block SHALL have parameter SEED, default 16'hACE1: LFSR reset value; it SHALL be nonzero.
REQ-002 The block SHALL have parameter GAP_BITS, default 2: number of LFSR low bits used to set the idle gap, legal range 1..4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_b, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port val, output, 1 bit: valid strobe; high for exactly one clk cycle per transferred word.
REQ-006 The block SHALL have port data, output, 8 bits: the payload word, qualified by val.

Function
REQ-007 The block SHALL be a free-running producer with no back-pressure input; every val pulse is one completed transfer.
REQ-008 The block SHALL implement the states WAIT and SEND.
REQ-009 In WAIT, the block SHALL decrement an idle counter each cycle; when the counter equals 1, the next state SHALL be SEND.
REQ-010 SEND SHALL last exactly one cycle, with val=1; the next state SHALL always be WAIT.
REQ-011 On the SEND->WAIT edge:
- the 16-bit LFSR SHALL advance one step;
- the idle counter SHALL load (new LFSR[GAP_BITS-1:0]) + 1, giving 1..2^GAP_BITS cycles.
REQ-012 The LFSR SHALL be Fibonacci, shift-left:
- feedback bit = b15 ^ b13 ^ b12 ^ b10 (x^16+x^14+x^13+x^11+1);
- feedback enters bit 0.
REQ-013 An 8-bit sequence counter SHALL hold the next payload value.
REQ-014 On the WAIT->SEND edge, data SHALL load the sequence counter, and the sequence counter SHALL increment.
REQ-015 The sequence counter SHALL wrap 8'hFF -> 8'h00 without any flag or stall.
REQ-016 data SHALL change only on edges where val rises; it SHALL hold its value while val=0.
REQ-017 val and data SHALL be driven directly from flops, with no combinational path from any input.
REQ-018 The LFSR SHALL never reach the all-zero value; SEED=0 is illegal.

Reset
REQ-019 While rst_b=0, the block SHALL immediately and asynchronously force:
- val=0, data=8'h00;
- sequence counter=8'h00;
- LFSR=SEED;
- state=WAIT;
- idle counter=SEED[GAP_BITS-1:0]+1.
REQ-020 Reset asserted mid-transfer (in SEND) SHALL drop val in the same instant, and the interrupted word SHALL NOT be re-sent.
REQ-021 After rst_b rises, the first val SHALL assert after the idle count expires; with default parameters, val rises on the 2nd rising clk edge after release.

Structure
REQ-022 Package prod_pkg SHALL hold:
- the state enum (WAIT, SEND);
- the LFSR width (16) and tap mask;
- the default SEED;
- the data width (8).
REQ-023 The LFSR SHALL be a sub-module prod_lfsr with ports clk, rst_b, step, seed and q[15:0].
REQ-024 The FSM and the counters SHALL reside in prod.

Verification
REQ-025 Reset start: clk period 100 ns, rst_b low 0-25 ns, then high -> val=0 and data=00 during reset; first val pulse on the 2nd rising edge after release, with data=8'h00.
REQ-026 Second gap: after the first transfer the LFSR becomes 16'h59C3 -> idle gap of 4 cycles, then val pulses with data=8'h01.
REQ-027 Pulse width: run 100 cycles -> every val pulse is exactly 1 cycle wide, gaps lie within 1..4 cycles, and data increments by exactly 1 per pulse.
REQ-028 Wrap-around: run until 257 transfers -> data sequence 8'hFE, 8'hFF, 8'h00, 8'h01 with no missing value.
REQ-029 Reset mid-SEND: pull rst_b low while val=1 -> val=0 immediately; after release, the sequence restarts at data=8'h00 with a gap of 2.
REQ-030 Data stability: check data between pulses -> data is unchanged on every edge where val does not rise.
